// File: rtl/vc_request_gen.sv
// VC request generator for an iSLIP VC allocator: per-input-VC FSMs, output VC ownership and credits.
// Define VC_REQ_ERR_CHECK_EN to build the sticky protocol-error detector; otherwise err is tied low.
module vc_request_gen #(
  parameter int PORTS     = 5,
  parameter int CHANNELS  = 12,
  parameter int BUF_DEPTH = 4,
  localparam int NUM_REQ  = PORTS * CHANNELS,
  localparam int PW       = $clog2(PORTS),
  localparam int VW       = $clog2(NUM_REQ),
  localparam int CW       = $clog2(BUF_DEPTH + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                head_valid,
  input  logic [NUM_REQ-1:0][PW-1:0]        head_route,
  input  logic [NUM_REQ-1:0]                flit_send,
  input  logic [NUM_REQ-1:0]                flit_tail,
  input  logic [NUM_REQ-1:0]                credit_ret,
  input  logic [NUM_REQ-1:0][NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0][NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]                vc_active,
  output logic [NUM_REQ-1:0][VW-1:0]        vc_sel,
  output logic [NUM_REQ-1:0]                vc_credit_ok,
  output logic                              err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACTIVE} state_t;

  state_t          state_q  [NUM_REQ];
  state_t          state_d  [NUM_REQ];
  logic [PW-1:0]   route_q  [NUM_REQ];
  logic [PW-1:0]   route_d  [NUM_REQ];
  logic [VW-1:0]   sel_q    [NUM_REQ];
  logic [VW-1:0]   sel_d    [NUM_REQ];
  logic [CW-1:0]   credit_q [NUM_REQ];
  logic [CW-1:0]   credit_d [NUM_REQ];
  logic [NUM_REQ-1:0] busy_q, busy_d;

  logic [NUM_REQ-1:0]         row_won;
  logic [NUM_REQ-1:0]         col_won;
  logic [NUM_REQ-1:0][VW-1:0] win_sel;
  logic [NUM_REQ-1:0]         send_ok, tail_ok;
  logic [NUM_REQ-1:0]         dec, vc_free;
  logic                       found;

  // Grant resolution: each row keeps its lowest requested j, then each column keeps its lowest row.
  always_comb begin
    row_won = '0;
    col_won = '0;
    win_sel = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      found = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && gnt[i][j] && req[i][j]) begin
          found = 1'b1;
          if (!col_won[j]) begin
            col_won[j] = 1'b1;
            row_won[i] = 1'b1;
            win_sel[i] = VW'(j);
          end
        end
      end
    end
  end

  // A send only counts for an owning input with downstream space; anything else is dropped.
  always_comb begin
    send_ok = '0;
    tail_ok = '0;
    dec     = '0;
    vc_free = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      send_ok[i] = (state_q[i] == S_ACTIVE) && flit_send[i] && (credit_q[sel_q[i]] != '0);
      tail_ok[i] = send_ok[i] && flit_tail[i];
      if (send_ok[i]) dec[sel_q[i]] = 1'b1;
      if (tail_ok[i]) vc_free[sel_q[i]] = 1'b1;
    end
  end

  always_comb begin
    for (int j = 0; j < NUM_REQ; j++) begin
      credit_d[j] = credit_q[j];
      if (dec[j] && !credit_ret[j])
        credit_d[j] = credit_q[j] - CW'(1);
      else if (credit_ret[j] && !dec[j] && credit_q[j] != CW'(BUF_DEPTH))
        credit_d[j] = credit_q[j] + CW'(1);
    end
    busy_d = (busy_q & ~vc_free) | col_won;
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      state_d[i] = state_q[i];
      route_d[i] = route_q[i];
      sel_d[i]   = sel_q[i];
      case (state_q[i])
        S_IDLE: begin
          if (head_valid[i]) begin
            state_d[i] = S_WAIT;
            route_d[i] = head_route[i];
          end
        end
        S_WAIT: begin
          if (row_won[i]) begin
            state_d[i] = S_ACTIVE;
            sel_d[i]   = win_sel[i];
          end
        end
        S_ACTIVE: begin
          if (tail_ok[i]) state_d[i] = S_IDLE;
        end
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        state_q[i]  <= S_IDLE;
        route_q[i]  <= '0;
        sel_q[i]    <= '0;
        credit_q[i] <= CW'(BUF_DEPTH);
      end
      busy_q <= '0;
    end else begin
      state_q  <= state_d;
      route_q  <= route_d;
      sel_q    <= sel_d;
      credit_q <= credit_d;
      busy_q   <= busy_d;
    end
  end

  // Out-of-range routes never match any j / CHANNELS, so such an input parks in WAIT.
  always_comb begin
    req          = '0;
    vc_active    = '0;
    vc_credit_ok = '0;
    vc_sel       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      vc_active[i]    = (state_q[i] == S_ACTIVE);
      vc_sel[i]       = sel_q[i];
      vc_credit_ok[i] = vc_active[i] && (credit_q[sel_q[i]] != '0);
      for (int j = 0; j < NUM_REQ; j++) begin
        req[i][j] = (state_q[i] == S_WAIT) && (route_q[i] == PW'(j / CHANNELS)) &&
                    !busy_q[j] && (credit_q[j] != '0);
      end
    end
  end

`ifdef VC_REQ_ERR_CHECK_EN
  logic               err_q;
  logic               err_hit;
  logic [NUM_REQ-1:0] col_seen;

  always_comb begin
    err_hit  = |(gnt & ~req);
    col_seen = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if ((gnt[i] & (gnt[i] - NUM_REQ'(1))) != '0) err_hit = 1'b1;
      if ((gnt[i] & col_seen) != '0) err_hit = 1'b1;
      col_seen = col_seen | gnt[i];
      if (flit_send[i] && state_q[i] != S_ACTIVE) err_hit = 1'b1;
      if (flit_send[i] && state_q[i] == S_ACTIVE && credit_q[sel_q[i]] == '0) err_hit = 1'b1;
      if (credit_ret[i] && credit_q[i] == CW'(BUF_DEPTH)) err_hit = 1'b1;
      if (head_valid[i] && state_q[i] == S_IDLE && int'(head_route[i]) >= PORTS) err_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          err_q <= 1'b0;
    else if (err_hit) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
